// File: rtl/hsv_pkg.sv
// Shared widths, FSM encodings and window-test helpers for the HSV blob tracker.
package hsv_pkg;

  localparam int X_W_DEF       = 11;
  localparam int Y_W_DEF       = 10;
  localparam int CNT_W_DEF     = 20;
  localparam int SUM_W_DEF     = 31;
  localparam int MIN_COUNT_DEF = 64;
  localparam int CH_W          = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_ACCUM = 2'd0;
  localparam state_t ST_DIV_X = 2'd1;
  localparam state_t ST_DIV_Y = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // A hue window with lo > hi wraps through 0 (e.g. reds spanning 240..15).
  function automatic logic hue_in_window(input logic [CH_W-1:0] hue,
                                         input logic [CH_W-1:0] lo,
                                         input logic [CH_W-1:0] hi);
    logic res;
    if (lo <= hi) res = (hue >= lo) && (hue <= hi);
    else          res = (hue >= lo) || (hue <= hi);
    return res;
  endfunction

  function automatic logic in_range(input logic [CH_W-1:0] val,
                                    input logic [CH_W-1:0] lo,
                                    input logic [CH_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, done pulses exactly
// DVD_W+1 cycles after the start cycle.
module seq_divider
  import hsv_pkg::*;
#(
  parameter int DVD_W = SUM_W_DEF,
  parameter int DVS_W = CNT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic [DVD_W-1:0] quotient,
  output logic             done
);

  localparam int STEP_W = $clog2(DVD_W + 1);

  logic [DVS_W-1:0]  rem;
  logic [DVS_W-1:0]  dvs;
  logic [STEP_W-1:0] steps;
  logic [DVS_W:0]    trial;
  logic              fits;
  logic [DVS_W-1:0]  rem_next;

  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    trial    = {rem, quotient[DVD_W-1]};
    fits     = trial >= {1'b0, dvs};
    rem_next = trial[DVS_W-1:0];
    if (fits) rem_next = DVS_W'(trial - {1'b0, dvs});
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
      steps    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem      <= '0;
        dvs      <= divisor;
        quotient <= dividend;
        steps    <= STEP_W'(DVD_W);
      end else if (steps != '0) begin
        rem      <= rem_next;
        quotient <= {quotient[DVD_W-2:0], fits};
        steps    <= steps - 1'b1;
        if (steps == STEP_W'(1)) done <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hsv_blob_tracker.sv
// Classifies the rgb2hsv pixel stream against a runtime HSV window and
// reports the per-frame centroid of in-band pixels.
module hsv_blob_tracker
  import hsv_pkg::*;
#(
  parameter int X_W       = X_W_DEF,
  parameter int Y_W       = Y_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int SUM_W     = SUM_W_DEF,
  parameter int MIN_COUNT = MIN_COUNT_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [CH_W-1:0] h,
  input  logic [CH_W-1:0] s,
  input  logic [CH_W-1:0] v,
  input  logic [X_W-1:0]  x,
  input  logic [Y_W-1:0]  y,
  input  logic            pixel_valid,
  input  logic            frame_end,
  input  logic [CH_W-1:0] h_min,
  input  logic [CH_W-1:0] h_max,
  input  logic [CH_W-1:0] s_min,
  input  logic [CH_W-1:0] s_max,
  input  logic [CH_W-1:0] v_min,
  input  logic [CH_W-1:0] v_max,
  output logic            mask,
  output logic            mask_valid,
  output logic [X_W-1:0]  cx,
  output logic [Y_W-1:0]  cy,
  output logic            found,
  output logic            centroid_valid,
  output logic            busy,
  output logic            dropped
);

  state_t           state;
  logic             hit;
  logic [CNT_W-1:0] cnt, cnt_next, snap_cnt;
  logic [SUM_W-1:0] sum_x, sum_y, sum_x_next, sum_y_next, snap_sum_y;
  logic [CNT_W:0]   cnt_add;
  logic [SUM_W:0]   sx_add, sy_add;
  logic             result_ok;
  logic [X_W-1:0]   qx;

  logic             start_x, start_y;
  logic [SUM_W-1:0] div_dividend, div_quo;
  logic [CNT_W-1:0] div_divisor;
  logic             div_done;
  logic             unused_quo_bits;

  assign hit = pixel_valid
             && hue_in_window(h, h_min, h_max)
             && in_range(s, s_min, s_max)
             && in_range(v, v_min, v_max);

  // Next-accumulator values include this cycle's pixel, so a pixel arriving
  // with frame_end lands in the snapshot of the ending frame.
  always_comb begin
    cnt_add    = {1'b0, cnt} + (CNT_W+1)'(hit);
    sx_add     = {1'b0, sum_x} + (hit ? (SUM_W+1)'(x) : '0);
    sy_add     = {1'b0, sum_y} + (hit ? (SUM_W+1)'(y) : '0);
    cnt_next   = cnt_add[CNT_W] ? '1 : cnt_add[CNT_W-1:0];
    sum_x_next = sx_add[SUM_W]  ? '1 : sx_add[SUM_W-1:0];
    sum_y_next = sy_add[SUM_W]  ? '1 : sy_add[SUM_W-1:0];
  end

  // X division starts straight from the live sums in the frame_end cycle;
  // Y follows from the snapshot the moment X completes.
  assign start_x = (state == ST_ACCUM) && frame_end
                && (cnt_next >= CNT_W'(MIN_COUNT));
  assign start_y = (state == ST_DIV_X) && div_done;

  assign div_dividend = start_x ? sum_x_next : snap_sum_y;
  assign div_divisor  = start_x ? cnt_next   : snap_cnt;

  seq_divider #(
    .DVD_W (SUM_W),
    .DVS_W (CNT_W)
  ) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (start_x | start_y),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .quotient (div_quo),
    .done     (div_done)
  );

  assign unused_quo_bits = ^div_quo[SUM_W-1:X_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_ACCUM;
      mask           <= 1'b0;
      mask_valid     <= 1'b0;
      cnt            <= '0;
      sum_x          <= '0;
      sum_y          <= '0;
      snap_cnt       <= '0;
      snap_sum_y     <= '0;
      result_ok      <= 1'b0;
      qx             <= '0;
      cx             <= '0;
      cy             <= '0;
      found          <= 1'b0;
      centroid_valid <= 1'b0;
      busy           <= 1'b0;
      dropped        <= 1'b0;
    end else begin
      mask           <= hit;
      mask_valid     <= pixel_valid;
      centroid_valid <= 1'b0;
      dropped        <= frame_end && (state != ST_ACCUM);

      if (frame_end) begin
        cnt   <= '0;
        sum_x <= '0;
        sum_y <= '0;
      end else begin
        cnt   <= cnt_next;
        sum_x <= sum_x_next;
        sum_y <= sum_y_next;
      end

      case (state)
        ST_ACCUM: begin
          if (frame_end) begin
            snap_cnt   <= cnt_next;
            snap_sum_y <= sum_y_next;
            result_ok  <= start_x;
            if (start_x) begin
              busy  <= 1'b1;
              state <= ST_DIV_X;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_DIV_X: begin
          if (div_done) begin
            qx    <= div_quo[X_W-1:0];
            state <= ST_DIV_Y;
          end
        end
        ST_DIV_Y: begin
          if (div_done) state <= ST_DONE;
        end
        ST_DONE: begin
          centroid_valid <= 1'b1;
          found          <= result_ok;
          busy           <= 1'b0;
          if (result_ok) begin
            cx <= qx;
            cy <= div_quo[Y_W-1:0];
          end
          state <= ST_ACCUM;
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_hsv_blob_tracker.sv
// Directed bench for hsv_blob_tracker: mask window tests and frame centroids.
module tb_hsv_blob_tracker;
  import hsv_pkg::*;

  localparam int X_W = 11;
  localparam int Y_W = 10;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [7:0]     h = '0, s = '0, v = '0;
  logic [X_W-1:0] x = '0;
  logic [Y_W-1:0] y = '0;
  logic           pixel_valid = 1'b0, frame_end = 1'b0;
  logic [7:0]     h_min = 8'd100, h_max = 8'd180;
  logic [7:0]     s_min = 8'd50,  s_max = 8'd255;
  logic [7:0]     v_min = 8'd50,  v_max = 8'd255;
  logic           mask, mask_valid, found, centroid_valid, busy, dropped;
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;

  int vectors = 0;
  int miscompares = 0;

  hsv_blob_tracker dut (
    .clock(clock), .reset(reset), .h(h), .s(s), .v(v), .x(x), .y(y),
    .pixel_valid(pixel_valid), .frame_end(frame_end),
    .h_min(h_min), .h_max(h_max), .s_min(s_min), .s_max(s_max),
    .v_min(v_min), .v_max(v_max),
    .mask(mask), .mask_valid(mask_valid), .cx(cx), .cy(cy), .found(found),
    .centroid_valid(centroid_valid), .busy(busy), .dropped(dropped)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [7:0] hh, input logic [X_W-1:0] xx,
                       input logic [Y_W-1:0] yy, input logic pv, input logic fe);
    h = hh; s = 8'd155; v = 8'd222; x = xx; y = yy;
    pixel_valid = pv; frame_end = fe;
  endtask

  // 8x8 block at (x0,y0); the first n_in pixels are in band, the rest not.
  // frame_end rides on the 64th pixel.
  task automatic send_frame(input int x0, input int y0, input int n_in);
    for (int i = 0; i < 64; i++) begin
      drive((i < n_in) ? 8'd140 : 8'd20, X_W'(x0 + i % 8), Y_W'(y0 + i / 8),
            1'b1, i == 63);
      tick;
    end
    drive(8'd0, '0, '0, 1'b0, 1'b0);
  endtask

  // Called in cycle frame_end+1; returns the offset at which centroid_valid rose.
  task automatic wait_result(input logic exp_busy, output int lat, output int busy_err);
    lat = 1;
    busy_err = 0;
    while (!centroid_valid && lat < 200) begin
      if (busy !== exp_busy) busy_err++;
      tick;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int lat, input int busy_err,
                              input int exp_lat, input int exp_cx, input int exp_cy,
                              input logic exp_found);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_during"}, busy_err, 0);
    check({tag, "_busy_at_valid"}, busy, 1'b0);
    check({tag, "_found"}, found, exp_found);
    check({tag, "_cx"}, cx, exp_cx);
    check({tag, "_cy"}, cy, exp_cy);
    tick;
    check({tag, "_valid_one_cycle"}, centroid_valid, 1'b0);
  endtask

  typedef struct { logic [7:0] hue; logic exp; } wrap_vec_t;
  wrap_vec_t wrap_tab[6] = '{'{8'd250, 1'b1}, '{8'd5, 1'b1}, '{8'd15, 1'b1},
                             '{8'd100, 1'b0}, '{8'd240, 1'b1}, '{8'd16, 1'b0}};

  initial begin
    int lat, busy_err, drops, drop_at, cv_seen;

    repeat (3) tick;
    reset = 1'b0;
    check("reset_flags", {mask, mask_valid, found, centroid_valid, busy, dropped}, 6'd0);
    check("reset_cx", cx, 0);
    check("reset_cy", cy, 0);

    drive(8'd140, '0, '0, 1'b1, 1'b0); tick;
    check("inband_mask", mask, 1'b1);
    check("inband_mask_valid", mask_valid, 1'b1);
    drive(8'd20, '0, '0, 1'b1, 1'b0); tick;
    check("hue_out_mask", mask, 1'b0);
    check("hue_out_mask_valid", mask_valid, 1'b1);
    drive(8'd140, '0, '0, 1'b1, 1'b0); s = 8'd30; tick;
    check("sat_out_mask", mask, 1'b0);
    drive(8'd140, '0, '0, 1'b0, 1'b0); tick;
    check("novalid_mask", mask, 1'b0);
    check("novalid_mask_valid", mask_valid, 1'b0);

    h_min = 8'd240; h_max = 8'd15; s_min = 8'd0; v_min = 8'd0;
    for (int i = 0; i < 6; i++) begin
      drive(wrap_tab[i].hue, '0, '0, 1'b1, 1'b0); tick;
      check($sformatf("wrap_h%0d", wrap_tab[i].hue), mask, wrap_tab[i].exp);
    end

    // Flush the mask-test pixels from the accumulators.
    drive(8'd0, '0, '0, 1'b0, 1'b0);
    reset = 1'b1; tick; reset = 1'b0;
    h_min = 8'd100; h_max = 8'd180; s_min = 8'd50; v_min = 8'd50;

    send_frame(100, 50, 64);
    wait_result(1'b1, lat, busy_err);
    check_result("frame_a", lat, busy_err, 66, 103, 53, 1'b1);

    send_frame(200, 10, 63);
    wait_result(1'b0, lat, busy_err);
    check_result("low_count", lat, busy_err, 2, 103, 53, 1'b0);

    // Stray in-band pixels plus a second frame_end during the division.
    send_frame(100, 50, 64);
    lat = 1; drops = 0; drop_at = 0;
    while (!centroid_valid && lat < 200) begin
      if (lat >= 5 && lat < 15) drive(8'd140, X_W'(1000), Y_W'(900), 1'b1, 1'b0);
      else if (lat == 20)       drive(8'd20, '0, '0, 1'b0, 1'b1);
      else                      drive(8'd0, '0, '0, 1'b0, 1'b0);
      tick;
      lat++;
      if (dropped) begin drops++; drop_at = lat; end
    end
    drive(8'd0, '0, '0, 1'b0, 1'b0);
    check("drop_count", drops, 1);
    check("drop_cycle", drop_at, 21);
    check_result("drop_inflight", lat, 0, 66, 103, 53, 1'b1);

    send_frame(200, 10, 64);
    wait_result(1'b1, lat, busy_err);
    check_result("after_drop", lat, busy_err, 66, 203, 13, 1'b1);

    send_frame(100, 50, 64);
    repeat (29) tick;
    reset = 1'b1; tick; reset = 1'b0;
    check("midreset_flags", {mask, mask_valid, found, centroid_valid, busy, dropped}, 6'd0);
    check("midreset_cx", cx, 0);
    check("midreset_cy", cy, 0);
    cv_seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick;
      if (centroid_valid) cv_seen++;
    end
    check("midreset_no_valid", cv_seen, 0);

    send_frame(200, 10, 64);
    wait_result(1'b1, lat, busy_err);
    check_result("after_reset", lat, busy_err, 66, 203, 13, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
